// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the datapath and a word-addressed
// data memory. Sub-word stores are done as read-modify-write; loads return
// sign- or zero-extended lane data. One request is outstanding at a time.
// Optional build macro MISALIGN_TRAP_EN: misaligned requests respond with
// rsp_err instead of being silently aligned.
`timescale 1ns/1ps
module lsu_mem_ctrl #(
  parameter int N     = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we,
  input  logic [N-1:0] mem_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        r_we;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic [1:0]   acc_size;
  logic [1:0]   acc_lane;
  logic         acc_mis;
  logic         acc_trap;
  logic [N-1:0] acc_index;

  logic [4:0]   sh_amt;
  logic [N-1:0] rd_shift;
  logic [N-1:0] load_ext;
  logic [N-1:0] lane_mask;
  logic [N-1:0] lane_data;
  logic [N-1:0] merged;

  // Upper address bits beyond the memory depth wrap away by design.
  logic unused_bits;
  assign unused_bits = &{1'b0, acc_mis, req_addr[N-1:AW+2]};

  // Word index truncated to the memory depth (modulo DEPTH).
  assign acc_index = {{(N-AW){1'b0}}, req_addr[AW+1:2]};
  assign sh_amt    = {r_lane, 3'b000};

  // Decode the incoming request: normalised size, aligned lane, misalignment.
  always_comb begin
    acc_size = (req_size == 2'b11) ? SZ_WORD : req_size;
    acc_lane = req_addr[1:0];
    acc_mis  = 1'b0;
    if (acc_size == SZ_HALF) begin
      acc_mis  = req_addr[0];
      acc_lane = {req_addr[1], 1'b0};
    end else if (acc_size == SZ_WORD) begin
      acc_mis  = |req_addr[1:0];
      acc_lane = 2'b00;
    end
    acc_trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    acc_trap = acc_mis;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    rd_shift  = mem_rdata >> sh_amt;
    load_ext  = rd_shift;
    lane_mask = '1;
    lane_data = {{(N-16){1'b0}}, r_wdata};
    case (r_size)
      SZ_BYTE: begin
        load_ext  = r_unsigned ? {{(N-8){1'b0}}, rd_shift[7:0]}
                               : {{(N-8){rd_shift[7]}}, rd_shift[7:0]};
        lane_mask = {{(N-8){1'b0}}, 8'hFF} << sh_amt;
        lane_data = {{(N-8){1'b0}}, r_wdata[7:0]} << sh_amt;
      end
      SZ_HALF: begin
        load_ext  = r_unsigned ? {{(N-16){1'b0}}, rd_shift[15:0]}
                               : {{(N-16){rd_shift[15]}}, rd_shift[15:0]};
        lane_mask = {{(N-16){1'b0}}, 16'hFFFF} << sh_amt;
        lane_data = {{(N-16){1'b0}}, r_wdata} << sh_amt;
      end
      default: ;
    endcase
    merged = (mem_rdata & ~lane_mask) | (lane_data & lane_mask);
  end

  // Request FSM with registered handshake, memory and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= '0;
      r_lane     <= '0;
      r_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_size     <= acc_size;
            r_lane     <= acc_lane;
            r_wdata    <= req_wdata[15:0];
            if (acc_trap) begin
              // Trapped access skips memory entirely.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= acc_index;
              if (req_we && acc_size == SZ_WORD) begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (r_we) begin
            state     <= WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= merged;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_ext;
          end
        end
        WRITE: begin
          state     <= RESP;
          mem_we    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: self-checking bench for lsu_mem_ctrl with a behavioural
// word memory and a scoreboard of expected responses and memory writes.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lat;
  } rsp_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  rsp_exp_t sb_q[$];
  wr_exp_t  wr_q[$];

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  logic        mem_init;
  logic        poke_en;
  logic [4:0]  poke_idx;
  logic [31:0] poke_data;

  int checks   = 0;
  int failures = 0;

  lsu_mem_ctrl #(.N(32), .DEPTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned i);
    return {8'(i), 8'hC3, 8'(i + 5), 8'h5A};
  endfunction

  assign mem_rdata = (mem_addr < 32'd32) ? mem[mem_addr[4:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: pushes expected response and write, updates ref_mem.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic exp_wr);
    rsp_exp_t    e;
    wr_exp_t     w;
    logic [1:0]  sz;
    logic [1:0]  off;
    int unsigned idx;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    logic        trap;
    sz = (size == 2'b11) ? 2'b10 : size;
    off = addr[1:0];
    if (sz == 2'b01) off[0] = 1'b0;
    if (sz == 2'b10) off = 2'b00;
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (off != addr[1:0]);
`endif
    idx = (addr >> 2) % 32;
    word = ref_mem[idx];
    e.err = trap;
    e.rdata = 32'h0;
    exp_wr = 1'b0;
    if (trap) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat = 2;
      b = word[8*off +: 8];
      h = word[16*off[1] +: 16];
      case (sz)
        2'b00:   e.rdata = uns ? {24'h0, b} : {{24{b[7]}}, b};
        2'b01:   e.rdata = uns ? {16'h0, h} : {{16{h[15]}}, h};
        default: e.rdata = word;
      endcase
    end else begin
      e.lat = (sz == 2'b10) ? 2 : 3;
      case (sz)
        2'b00:   word[8*off +: 8] = wdata[7:0];
        2'b01:   word[16*off[1] +: 16] = wdata[15:0];
        default: word = wdata;
      endcase
      ref_mem[idx] = word;
      w.addr = idx;
      w.data = word;
      wr_q.push_back(w);
      exp_wr = 1'b1;
    end
    sb_q.push_back(e);
  endtask

  task automatic poke(input int unsigned idx, input logic [31:0] data);
    @(negedge clk);
    poke_en = 1'b1;
    poke_idx = 5'(idx);
    poke_data = data;
    @(posedge clk);
    #1 poke_en = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_wr;
    int unsigned k;
    int unsigned n;
    int unsigned wr_seen;
    logic        done;
    rsp_exp_t    e;
    wr_exp_t     w;
    model(we, size, uns, addr, wdata, exp_wr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance; the DUT must use its latched copy.
    req_valid = 1'b0; req_we = ~we; req_size = ~size; req_unsigned = ~uns;
    req_addr = $urandom; req_wdata = $urandom;
    k = 0; done = 1'b0; wr_seen = 0;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
      if (mem_we) begin
        wr_seen++;
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          check({tag, "_waddr"}, mem_addr, w.addr);
          check({tag, "_wdata"}, mem_wdata, w.data);
        end
      end
      if (rsp_valid) begin
        done = 1'b1;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check({tag, "_rdata"}, rsp_rdata, e.rdata);
          check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
          check({tag, "_latency"}, k, e.lat);
        end else begin
          check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end
        check({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      sb_q.delete();
    end
    check({tag, "_nwrites"}, wr_seen, 32'(exp_wr));
    wr_q.delete();
  endtask

  task automatic run_b2b();
    logic        d;
    int          step;
    int          acc;
    int          acc_step;
    int          last_rsp;
    int          rsp_cnt;
    int          writes;
    rsp_exp_t    e;
    model(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, d);
    model(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, d);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h0;
    step = 0; acc = 0; acc_step = 0; last_rsp = -1000; rsp_cnt = 0; writes = 0;
    while (rsp_cnt < 2 && step < 30) begin
      if (mem_we) writes++;
      if (rsp_valid) begin
        rsp_cnt++;
        last_rsp = step;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("b2b_rdata", rsp_rdata, e.rdata);
        end
        check("b2b_ready_in_resp", 32'(req_ready), 32'd0);
      end else if (acc > 0 && step == acc_step + 1) begin
        check("b2b_ready_in_read", 32'(req_ready), 32'd0);
      end
      if (req_valid && req_ready) begin
        if (acc == 1) check("b2b_accept_gap", 32'(step - last_rsp), 32'd1);
        acc++;
        acc_step = step;
        @(posedge clk);
        #1;
        if (acc == 1) begin
          req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h6;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      step++;
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd2);
    check("b2b_responses", 32'(rsp_cnt), 32'd2);
    check("b2b_writes", 32'(writes), 32'd0);
    sb_q.delete();
  endtask

  task automatic run_abort();
    int unsigned bad;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h00000077;
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_in_read", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_after_rst", 32'(req_ready), 32'd1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we || rsp_valid) bad++;
    end
    check("abort_quiet", bad, 32'd0);
    check("abort_mem_intact", mem[4], ref_mem[4]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned bad;
    rst = 1'b1; mem_init = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_data = '0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0; mem_init = 1'b0; req_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || mem_we || !req_ready) bad++;
    end
    check("rst_quiet", bad, 32'd0);

    run_req("sw_8",      1'b1, 2'b10, 1'b0, 32'h8,  32'hDEADBEEF);
    run_req("lw_8",      1'b0, 2'b10, 1'b0, 32'h8,  32'h0);
    poke(1, 32'h00000002);
    run_req("sb_6",      1'b1, 2'b00, 1'b0, 32'h6,  32'h000000AB);
    run_req("lb_6",      1'b0, 2'b00, 1'b0, 32'h6,  32'h0);
    run_req("lbu_6",     1'b0, 2'b00, 1'b1, 32'h6,  32'h0);
    run_req("lh_6",      1'b0, 2'b01, 1'b0, 32'h6,  32'h0);
    run_req("sh_e",      1'b1, 2'b01, 1'b0, 32'hE,  32'h1234ABCD);
    run_req("lh_e",      1'b0, 2'b01, 1'b0, 32'hE,  32'h0);
    run_req("lhu_e",     1'b0, 2'b01, 1'b1, 32'hE,  32'h0);
    run_req("lb_f",      1'b0, 2'b00, 1'b0, 32'hF,  32'h0);
    run_req("lbu_d",     1'b0, 2'b00, 1'b1, 32'hD,  32'h0);
    run_req("lw_wrap",   1'b0, 2'b10, 1'b0, 32'h88, 32'h0);
    run_req("sw_wrap",   1'b1, 2'b10, 1'b0, 32'h84, 32'hCAFEF00D);
    run_req("lw_4",      1'b0, 2'b10, 1'b0, 32'h4,  32'h0);
    run_req("lres_8",    1'b0, 2'b11, 1'b1, 32'h8,  32'h0);
    run_req("lw_mis5",   1'b0, 2'b10, 1'b0, 32'h5,  32'h0);
    run_req("sh_mis9",   1'b1, 2'b01, 1'b0, 32'h9,  32'h00005555);
    run_req("lhu_8",     1'b0, 2'b01, 1'b1, 32'h8,  32'h0);
    run_b2b();
    run_abort();
    run_req("lw_10",     1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
